// File: rtl/ip_backward_acc.sv
`default_nettype none
// ============================================================================
//  Module   : ip_backward_acc
//  Purpose  : Streaming fixed-point dot-product engine for the FC backward
//             pass. Accumulates WIDTH-wide slices across beats, then emits
//             one rounded, saturated, tagged result per vector.
//  Revision : 1.0 - initial release
// ============================================================================
module ip_backward_acc #(
    parameter int WIDTH  = 4,
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 2*DATA_W+8,
    parameter int ID_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_last,
    input  logic [ID_W-1:0]          in_id,
    input  logic signed [DATA_W-1:0] in_data [WIDTH-1:0],
    input  logic signed [DATA_W-1:0] weights [WIDTH-1:0],
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [ID_W-1:0]          out_id,
    output logic                     out_sat
);

    localparam int c_l  = $clog2(WIDTH);
    localparam int c_tw = 2*DATA_W + c_l;

    localparam logic signed [ACC_W-1:0]  c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] c_out_max = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] c_out_min = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]    c_half    = (ACC_W+1)'(1) << (FRAC_W-1);

    logic w_en;

    // Heap-ordered tree: leaves WIDTH..2*WIDTH-1 are the product stage, node 1 is the root.
    logic signed [c_tw-1:0] w_leaf [WIDTH];
    logic signed [c_tw-1:0] r_node [1:2*WIDTH-1];
    logic [c_l:0]           r_vld;
    logic [c_l:0]           r_last;
    logic [ID_W-1:0]        r_id [0:c_l];

    logic signed [ACC_W-1:0] r_acc;
    logic                    r_acc_sat;
    logic                    r_first;
    logic                    r_a_valid;
    logic signed [ACC_W-1:0] r_a_sum;
    logic                    r_a_sat;
    logic [ID_W-1:0]         r_a_id;

    logic                    r_out_valid;
    logic [DATA_W-1:0]       r_out_data;
    logic [ID_W-1:0]         r_out_id;
    logic                    r_out_sat;

    logic signed [ACC_W-1:0] w_base;
    logic signed [ACC_W-1:0] w_tree_ext;
    logic signed [ACC_W:0]   w_sum_wide;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W:0]   w_rnd;
    logic [ACC_W-DATA_W+1:0] w_hi;
    logic                    w_clip;
    logic [DATA_W-1:0]       w_out;

    assign w_en      = !r_out_valid || out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_sat   = r_out_sat;

    for (genvar i = 0; i < WIDTH; i++) begin : g_prod
        assign w_leaf[i] = c_tw'(in_data[i]) * c_tw'(weights[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vld  <= '0;
            r_last <= '0;
            for (int k = 0; k <= c_l; k++) r_id[k] <= '0;
            for (int n = 1; n < 2*WIDTH; n++) r_node[n] <= '0;
        end else if (w_en) begin
            r_vld[0]  <= in_valid;
            r_last[0] <= in_last;
            r_id[0]   <= in_id;
            for (int k = 1; k <= c_l; k++) begin
                r_vld[k]  <= r_vld[k-1];
                r_last[k] <= r_last[k-1];
                r_id[k]   <= r_id[k-1];
            end
            for (int n = 1; n < WIDTH; n++) r_node[n] <= r_node[2*n] + r_node[2*n+1];
            for (int i = 0; i < WIDTH; i++) r_node[WIDTH+i] <= w_leaf[i];
        end
    end

    // Saturating accumulate: one guard bit detects wrap past the ACC_W range.
    assign w_base     = r_first ? '0 : r_acc;
    assign w_tree_ext = ACC_W'(r_node[1]);
    assign w_sum_wide = (ACC_W+1)'(w_base) + (ACC_W+1)'(w_tree_ext);
    assign w_ovf      = w_sum_wide[ACC_W] ^ w_sum_wide[ACC_W-1];
    assign w_sum      = w_ovf ? (w_sum_wide[ACC_W] ? c_acc_min : c_acc_max)
                              : w_sum_wide[ACC_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_acc     <= '0;
            r_acc_sat <= 1'b0;
            r_first   <= 1'b1;
            r_a_valid <= 1'b0;
            r_a_sum   <= '0;
            r_a_sat   <= 1'b0;
            r_a_id    <= '0;
        end else if (w_en) begin
            r_a_valid <= 1'b0;
            if (r_vld[c_l]) begin
                if (r_last[c_l]) begin
                    r_a_valid <= 1'b1;
                    r_a_sum   <= w_sum;
                    r_a_sat   <= r_acc_sat | w_ovf;
                    r_a_id    <= r_id[c_l];
                    r_acc     <= '0;
                    r_acc_sat <= 1'b0;
                    r_first   <= 1'b1;
                end else begin
                    r_acc     <= w_sum;
                    r_acc_sat <= r_acc_sat | w_ovf;
                    r_first   <= 1'b0;
                end
            end
        end
    end

    // Round half toward +inf, then clip when the upper bits are not pure sign extension.
    assign w_rnd  = ($signed({r_a_sum[ACC_W-1], r_a_sum}) + c_half) >>> FRAC_W;
    assign w_hi   = w_rnd[ACC_W:DATA_W-1];
    assign w_clip = !((&w_hi) || !(|w_hi));
    assign w_out  = w_clip ? (w_rnd[ACC_W] ? c_out_min : c_out_max) : w_rnd[DATA_W-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= r_a_valid;
            if (r_a_valid) begin
                r_out_data <= w_out;
                r_out_id   <= r_a_id;
                r_out_sat  <= r_a_sat | w_clip;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ip_backward_acc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ip_backward_acc
//  Purpose  : Directed self-checking bench for ip_backward_acc.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ip_backward_acc;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic [7:0]        in_id;
    logic signed [15:0] in_data [3:0];
    logic signed [15:0] weights [3:0];
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [7:0]        out_id;
    logic              out_sat;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q_data [$];
    logic [7:0]  q_id   [$];
    logic        q_sat  [$];

    localparam logic [63:0] c_d1  = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    localparam logic [63:0] c_w1  = {4{16'h0100}};

    ip_backward_acc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_id     (in_id),
        .in_data   (in_data),
        .weights   (weights),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every completed output handshake, sampled half a cycle before the edge.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_id.push_back(out_id);
            q_sat.push_back(out_sat);
        end
    end

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at posedge+1; returns at posedge+1 of the accepting edge with in_valid low.
    task automatic send_beat(input logic [63:0] d, input logic [63:0] w,
                             input logic last, input logic [7:0] id);
        int n = 0;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = d[16*i +: 16];
            weights[i] = w[16*i +: 16];
        end
        in_last  = last;
        in_id    = id;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_value("in_ready timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_result(input string tag, input logic [15:0] ed,
                                 input logic [7:0] eid, input logic es);
        int n = 0;
        logic [15:0] d;
        logic [7:0]  id;
        logic        s;
        while (q_data.size() == 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q_data.size() == 0) begin
            check_value({tag, " timeout"}, 64'd0, 64'd1);
            return;
        end
        d  = q_data.pop_front();
        id = q_id.pop_front();
        s  = q_sat.pop_front();
        check_value({tag, " data"}, d, ed);
        check_value({tag, " id"}, id, eid);
        check_value({tag, " sat"}, s, es);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_id     = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data[i] = '0;
            weights[i] = '0;
        end

        // Reset state
        repeat (3) @(negedge clk);
        check_value("reset out_valid", out_valid, 1'b0);
        check_value("reset in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_value("post-reset out_data", out_data, 16'h0000);
        check_value("post-reset out_id", out_id, 8'h00);
        check_value("post-reset out_sat", out_sat, 1'b0);
        check_value("post-reset in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single beat: the accepting edge is edge 1; out_valid must be visible after edge 5.
        send_beat(c_d1, c_w1, 1'b1, 8'h11);
        n = 1;
        while (n < 30) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            n++;
        end
        check_value("single latency", n, 5);
        expect_result("single", 16'h0A00, 8'h11, 1'b0);

        // Multi-beat with one idle cycle between beats 2 and 3
        @(posedge clk);
        #1;
        send_beat(c_d1, c_w1, 1'b0, 8'h22);
        send_beat(c_d1, c_w1, 1'b0, 8'h22);
        @(posedge clk);
        #1;
        send_beat(c_d1, c_w1, 1'b1, 8'h22);
        expect_result("multi", 16'h1E00, 8'h22, 1'b0);
        repeat (10) @(negedge clk);
        check_value("multi single output", q_data.size(), 0);

        // Rounding: +0.5 LSB rounds up, -0.5 LSB rounds to zero
        @(posedge clk);
        #1;
        send_beat(64'h0001, 64'h0080, 1'b1, 8'h31);
        send_beat(64'hFFFF, 64'h0080, 1'b1, 8'h32);
        expect_result("round pos", 16'h0001, 8'h31, 1'b0);
        expect_result("round neg", 16'h0000, 8'h32, 1'b0);

        // Saturation, then a normal vector must report no saturation
        @(posedge clk);
        #1;
        send_beat({4{16'h7FFF}}, {4{16'h7FFF}}, 1'b1, 8'h41);
        send_beat({4{16'h8000}}, {4{16'h7FFF}}, 1'b1, 8'h42);
        send_beat(c_d1, c_w1, 1'b1, 8'h43);
        expect_result("sat pos", 16'h7FFF, 8'h41, 1'b1);
        expect_result("sat neg", 16'h8000, 8'h42, 1'b1);
        expect_result("sat clear", 16'h0A00, 8'h43, 1'b0);

        // Backpressure: result k is (k+1).0; stall starts right after id 0 leaves, so id 1 is held.
        @(posedge clk);
        #1;
        fork
            begin
                for (int k = 0; k < 6; k++)
                    send_beat({48'h0, 16'((k + 1) * 256)}, 64'h0100, 1'b1, 8'(k));
            end
            begin
                int m = 0;
                do begin
                    @(negedge clk);
                    m++;
                end while (!out_valid && m < 50);
                check_value("bp first valid", out_valid, 1'b1);
                @(posedge clk);
                #1 out_ready = 1'b0;
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    check_value("bp hold valid", out_valid, 1'b1);
                    check_value("bp in_ready low", in_ready, 1'b0);
                    check_value("bp hold data", out_data, 16'h0200);
                    check_value("bp hold id", out_id, 8'h01);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        for (int k = 0; k < 6; k++)
            expect_result("bp order", 16'((k + 1) * 256), 8'(k), 1'b0);

        // Reset mid-vector discards the two partial beats (would give 0x1200 otherwise)
        @(posedge clk);
        #1;
        send_beat(c_w1, c_w1, 1'b0, 8'h60);
        send_beat(c_w1, c_w1, 1'b0, 8'h60);
        reset = 1'b0;
        @(negedge clk);
        check_value("mid-reset out_valid", out_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (8) @(negedge clk);
        check_value("no stale output", q_data.size(), 0);
        @(posedge clk);
        #1;
        send_beat(c_d1, c_w1, 1'b1, 8'h61);
        expect_result("after reset", 16'h0A00, 8'h61, 1'b0);
        repeat (10) @(negedge clk);
        check_value("no extra output", q_data.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ip_backward_acc.md
# ip_backward_acc

Streaming fixed-point inner-product engine for the fully-connected backward pass. It accepts one WIDTH-element slice of the gradient vector and the matching weight slice per beat. It accumulates slices across a variable number of beats until `in_last`, then emits one rounded, saturated dot product tagged with its ID. It replaces the single-slice `ip_backward` wherever vector length exceeds WIDTH or downstream can stall.

## Interface

- `WIDTH`, 4: elements per beat; power of two, ≥2; L = log2(WIDTH).
- `DATA_W`, 16: signed two's-complement element/result width.
- `FRAC_W`, 8: fractional bits of inputs and result (Q(DATA_W-FRAC_W).FRAC_W).
- `ACC_W`, 2*DATA_W+8: signed accumulator width.
- `ID_W`, 8: tag width.

Ports:

- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `in_valid` in 1: beat present.
- `in_ready` out 1: beat accepted when `in_valid && in_ready`.
- `in_last` in 1: final beat of the current vector.
- `in_id` in ID_W: tag; sampled on the last beat only.
- `in_data` in DATA_W × [WIDTH-1:0] (unpacked array): gradient slice.
- `weights` in DATA_W × [WIDTH-1:0] (unpacked array): weight slice.
- `out_valid` out 1: result held until `out_ready`.
- `out_ready` in 1: consumer accepts.
- `out_data` out DATA_W: rounded, saturated dot product.
- `out_id` out ID_W: tag of the result.
- `out_sat` out 1: result was clipped (either at the accumulator or at the output).

## Operation

- Global enable `en = !out_valid || out_ready`. `in_ready = en`. When `en` = 0, every pipeline register (data, valid, last, id) holds.
- Stage M: WIDTH signed products, 2*DATA_W bits each, registered.
- Stages T1..TL: registered binary adder tree, one level per stage. Width grows by 1 bit per level with no overflow.
- Stage A (accumulate): on a valid tree beat:
  - `sum = (first ? 0 : acc) + tree`, saturating to the signed ACC_W range.
  - A sticky `acc_sat` flag records any clip.
  - `first` is set by reset and after every last beat; it is cleared by a non-last beat.
  - On a last beat: pass `sum`, `acc_sat` and the ID to stage O, then clear `acc` and `acc_sat`.
  - On a non-last beat: `acc <= sum`.
- Stage O (output):
  - `r = (sum + 2^(FRAC_W-1)) >>> FRAC_W`, i.e. round half toward +∞.
  - Clip `r` to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - `out_sat = acc_sat | clip`.
  - Load into `out_data`/`out_id`/`out_sat` and set `out_valid`.
- Output handshake:
  - `out_valid` clears on `out_ready` unless a new result loads in the same cycle.
  - Back-to-back results are allowed when `out_ready` stays high.
- A single-beat vector (`in_last` on its first beat) is legal.
- Vector length is unbounded; beats need not be contiguous (`in_valid` gaps are allowed mid-vector).
- Reset (asynchronous assert, synchronous-safe deassert):
  - all valid bits = 0, `acc` = 0, `acc_sat` = 0, `first` = 1.
  - `out_data` = 0, `out_id` = 0, `out_sat` = 0, `out_valid` = 0.
  - `in_ready` = 1 once reset is released.
  - Assertion mid-vector or mid-pipeline discards all partial work; no result from pre-reset beats ever appears.

## Timing

- Latency from the accepting edge of a last beat to `out_valid` high: L+3 cycles with no stall (5 for WIDTH=4).
- Throughput: one beat per cycle while `en` = 1.
- Stall cycles add latency 1:1; beats are never dropped or duplicated.
- `in_ready` is combinational from `out_valid`/`out_ready` only, not from `in_valid`.
- Results leave in the order their last beats were accepted.
- `out_data`, `out_id` and `out_sat` are stable whenever `out_valid` = 1 and `out_ready` = 0.

## Test plan

Defaults apply throughout; 1.0 = 0x0100.

- **Single beat:** `in_data` = {0x0100, 0x0200, 0x0300, 0x0400}, `weights` all 0x0100, `in_last` = 1, `in_id` = 0x11 -> `out_data` = 0x0A00, `out_id` = 0x11, `out_sat` = 0, `out_valid` exactly 5 cycles after acceptance.
- **Multi-beat with gap:** the same slice for 3 beats, one idle cycle between beats 2 and 3, `in_last` on beat 3 -> `out_data` = 0x1E00, and exactly one output.
- **Rounding:** `in_data[0]` = 0x0001, `weights[0]` = 0x0080, rest 0 -> 0x0001. `in_data[0]` = 0xFFFF, `weights[0]` = 0x0080 -> 0x0000.
- **Saturation:** all inputs and weights 0x7FFF -> 0x7FFF, `out_sat` = 1. `in_data` all 0x8000, `weights` all 0x7FFF -> 0x8000, `out_sat` = 1. The next normal vector reports `out_sat` = 0.
- **Backpressure:** send 6 single-beat vectors with ids 0..5 back-to-back; hold `out_ready` low for 10 cycles mid-stream -> `in_ready` falls while `out_valid && !out_ready`, the output is stable, and all 6 results arrive in id order with correct values.
- **Reset mid-vector:** 2 non-last beats of 0x0100 products, then `reset` low for 2 cycles, then a single-beat vector -> no output before the new vector, and its result excludes the pre-reset beats (0x0A00 for the first scenario's slice).
